// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and small decode helpers for the memory stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  typedef logic [3:0] icode_t;
  typedef logic [1:0] stat_t;

  function automatic logic is_rd(input icode_t icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
  endfunction

  function automatic logic is_wr(input icode_t icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  // Pop and return take their address from valA (old %rsp), everything else from valE.
  function automatic logic use_vala(input icode_t icode);
    return (icode == I_POPQ) || (icode == I_RET);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/y86_mem_stage_ws_if.sv
// M-stage inputs, W control and M/W outputs of the memory stage; master is the pipeline side.
interface y86_mem_stage_ws_if #(parameter int DATA_W = 64);
  logic [1:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic              W_stall;
  logic              W_bubble;

  logic              m_busy;
  logic [DATA_W-1:0] m_valM;
  logic [1:0]        m_stat;
  logic [1:0]        W_stat;
  logic [3:0]        W_icode;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;
  logic [3:0]        W_dstE;
  logic [3:0]        W_dstM;

  modport master (
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    input  m_busy, m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );

  modport slave (
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    output m_busy, m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/y86_data_mem.sv
// Byte-addressed little-endian data memory: combinational word read, registered word write.
module y86_data_mem #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int BYTES = DATA_W / 8;

  // No reset: contents survive rst_n.
  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_data[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[addr + AW'(i)] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/y86_mem_stage_ws.sv
// Y86-64 memory stage + M/W register; each access holds M for WAIT_CYCLES extra cycles via m_busy.
// W_stall holds W and freezes the op in READY; optional MEM_STATS_EN adds saturating access counters.
module y86_mem_stage_ws
  import y86_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  y86_mem_stage_ws_if.slave  bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]        stat_loads,
  output logic [31:0]        stat_stores,
  output logic [31:0]        stat_wait
`endif
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                AW         = $clog2(MEM_BYTES);
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_BYTES - BYTES);
  localparam logic [3:0]        WAIT_N     = 4'(WAIT_CYCLES);

  logic              rd_op;
  logic              wr_op;
  logic              mem_op;
  logic              aok;
  logic              fault;
  logic              busy;
  logic              leave;
  logic              wr_en;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        count;
  logic [3:0]        count_nxt;

  // M_cnd travels with the instruction but this stage never looks at it.
  logic unused_cnd;
  assign unused_cnd = bus.M_cnd;

  always_comb begin
    rd_op  = is_rd(bus.M_icode);
    wr_op  = is_wr(bus.M_icode);
    mem_op = rd_op || wr_op;
    aok    = (bus.M_stat == S_AOK);
    addr   = use_vala(bus.M_icode) ? bus.M_valA : bus.M_valE;
    // Full-width unsigned compare, so addresses that wrap past zero also fault.
    fault  = mem_op && aok && (addr > ADDR_LIMIT);
    // count never exceeds WAIT_N, so "!=" is the same as "<" here.
    busy   = mem_op && aok && (count != WAIT_N);
    leave  = !busy && !bus.W_stall;
    wr_en  = wr_op && aok && !fault && !busy && !bus.W_stall && !bus.W_bubble && rst_n;
  end

  y86_data_mem #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .addr    (addr[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_data (bus.M_valA)
  );

  assign bus.m_busy = busy;
  assign bus.m_valM = (rd_op && aok && !fault) ? rd_data : '0;
  assign bus.m_stat = fault ? S_ADR : bus.M_stat;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (busy) begin
          count_nxt = count + 4'd1;
          state_nxt = (count_nxt == WAIT_N) ? ST_READY : ST_WAIT;
        end else if (!bus.W_stall) begin
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_READY: begin
        if (!bus.W_stall) begin
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.W_stat  <= S_AOK;
      bus.W_icode <= I_NOP;
      bus.W_valE  <= '0;
      bus.W_valM  <= '0;
      bus.W_dstE  <= RNONE;
      bus.W_dstM  <= RNONE;
    end else if (bus.W_stall) begin
      bus.W_stat  <= bus.W_stat;
    end else if (busy || bus.W_bubble) begin
      bus.W_stat  <= S_AOK;
      bus.W_icode <= I_NOP;
      bus.W_valE  <= '0;
      bus.W_valM  <= '0;
      bus.W_dstE  <= RNONE;
      bus.W_dstM  <= RNONE;
    end else begin
      bus.W_stat  <= bus.m_stat;
      bus.W_icode <= bus.M_icode;
      bus.W_valE  <= bus.M_valE;
      bus.W_valM  <= bus.m_valM;
      bus.W_dstE  <= bus.M_dstE;
      bus.W_dstM  <= bus.M_dstM;
    end
  end

`ifdef MEM_STATS_EN
  logic rd_done;
  assign rd_done = rd_op && aok && !fault && leave && !bus.W_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_wait   <= '0;
    end else begin
      if (rd_done) stat_loads  <= sat_inc(stat_loads);
      if (wr_en)   stat_stores <= sat_inc(stat_stores);
      if (busy)    stat_wait   <= sat_inc(stat_wait);
    end
  end
`endif

endmodule

// File: tb/tb_y86_mem_stage_ws.sv
// Directed bench: four stage instances (WAIT_CYCLES 0,3,2,1) share one stimulus; sel picks the one checked.
module tb_y86_mem_stage_ws;
  import y86_pkg::*;

  localparam int WAITS [4] = '{0, 3, 2, 1};

  logic        clk;
  logic        rst_n;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;

  logic        o_busy   [4];
  logic [63:0] o_valM   [4];
  logic [1:0]  o_mstat  [4];
  logic [1:0]  o_wstat  [4];
  logic [3:0]  o_wicode [4];
  logic [63:0] o_wvalE  [4];
  logic [63:0] o_wvalM  [4];
  logic [3:0]  o_wdstE  [4];
  logic [3:0]  o_wdstM  [4];
`ifdef MEM_STATS_EN
  logic [31:0] o_sl [4];
  logic [31:0] o_ss [4];
  logic [31:0] o_sw [4];
`endif

  int          sel;
  int          total;
  int          bad;
  bit          ever_busy0;

  logic        busy;
  logic [63:0] valM;
  logic [1:0]  mstat;
  logic [1:0]  wstat;
  logic [3:0]  wicode;
  logic [63:0] wvalE;
  logic [63:0] wvalM;
  logic [3:0]  wdstE;
  logic [3:0]  wdstM;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    y86_mem_stage_ws_if #(.DATA_W(64)) bus ();
    assign bus.M_stat   = M_stat;
    assign bus.M_icode  = M_icode;
    assign bus.M_cnd    = M_cnd;
    assign bus.M_valE   = M_valE;
    assign bus.M_valA   = M_valA;
    assign bus.M_dstE   = M_dstE;
    assign bus.M_dstM   = M_dstM;
    assign bus.W_stall  = W_stall;
    assign bus.W_bubble = W_bubble;

    y86_mem_stage_ws #(
      .DATA_W      (64),
      .MEM_BYTES   (1024),
      .WAIT_CYCLES (WAITS[g])
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MEM_STATS_EN
      ,
      .stat_loads  (o_sl[g]),
      .stat_stores (o_ss[g]),
      .stat_wait   (o_sw[g])
`endif
    );

    assign o_busy[g]   = bus.m_busy;
    assign o_valM[g]   = bus.m_valM;
    assign o_mstat[g]  = bus.m_stat;
    assign o_wstat[g]  = bus.W_stat;
    assign o_wicode[g] = bus.W_icode;
    assign o_wvalE[g]  = bus.W_valE;
    assign o_wvalM[g]  = bus.W_valM;
    assign o_wdstE[g]  = bus.W_dstE;
    assign o_wdstM[g]  = bus.W_dstM;
  end

  always_comb begin
    busy   = o_busy[sel];
    valM   = o_valM[sel];
    mstat  = o_mstat[sel];
    wstat  = o_wstat[sel];
    wicode = o_wicode[sel];
    wvalE  = o_wvalE[sel];
    wvalM  = o_wvalM[sel];
    wdstE  = o_wdstE[sel];
    wdstM  = o_wdstM[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_busy[0] === 1'b1) ever_busy0 = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    M_stat  = S_AOK;
    M_icode = ic;
    M_cnd   = 1'b0;
    M_valE  = ve;
    M_valA  = va;
    M_dstE  = de;
    M_dstM  = dm;
  endtask

  task automatic idle(input int n);
    drive(I_NOP, 64'd0, 64'd0, RNONE, RNONE);
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    repeat (n) tick();
  endtask

  // Hold the op in M until busy drops, then clock it into W.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm);
    int n;
    drive(ic, ve, va, de, dm);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_timeout", 64'(n < 40), 64'd1);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 0;
    rst_n = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    drive(I_NOP, 64'd0, 64'd0, RNONE, RNONE);

    // Reset state
    #12;
    chk("rst_wicode", wicode, 4'h1);
    chk("rst_wstat",  wstat,  S_AOK);
    chk("rst_wvalE",  wvalE,  64'd0);
    chk("rst_wvalM",  wvalM,  64'd0);
    chk("rst_wdstE",  wdstE,  4'hF);
    chk("rst_wdstM",  wdstM,  4'hF);
    chk("rst_busy",   busy,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero wait states: store, load, non-AOK, bubble and stall handling
    drive(I_RMMOVQ, 64'd32, 64'h1122334455667788, RNONE, RNONE);
    #1;
    chk("w0_st_busy", busy, 1'b0);
    chk("w0_st_mstat", mstat, S_AOK);
    tick();
    chk("w0_st_wicode", wicode, I_RMMOVQ);
    chk("w0_st_wvalE", wvalE, 64'd32);

    drive(I_MRMOVQ, 64'd32, 64'd0, RNONE, 4'd3);
    #1;
    chk("w0_ld_valM", valM, 64'h1122334455667788);
    chk("w0_ld_busy", busy, 1'b0);
    tick();
    chk("w0_ld_wicode", wicode, I_MRMOVQ);
    chk("w0_ld_wvalM", wvalM, 64'h1122334455667788);
    chk("w0_ld_wdstM", wdstM, 4'd3);

    drive(I_MRMOVQ, 64'd32, 64'd0, RNONE, 4'd3);
    M_stat = S_INS;
    #1;
    chk("ins_valM", valM, 64'd0);
    chk("ins_mstat", mstat, S_INS);
    tick();
    chk("ins_wstat", wstat, S_INS);

    drive(I_MRMOVQ, 64'd32, 64'd0, RNONE, 4'd3);
    W_bubble = 1'b1;
    tick();
    chk("bub_wicode", wicode, I_NOP);
    chk("bub_wdstM", wdstM, RNONE);
    drive(I_RMMOVQ, 64'd32, 64'h000000000000FFFF, RNONE, RNONE);
    tick();
    W_bubble = 1'b0;
    drive(I_MRMOVQ, 64'd32, 64'd0, RNONE, 4'd3);
    #1;
    chk("bub_no_store", valM, 64'h1122334455667788);
    tick();

    drive(I_RMMOVQ, 64'd32, 64'h000000000000AAAA, RNONE, RNONE);
    W_stall = 1'b1;
    tick();
    chk("stall_hold_icode", wicode, I_MRMOVQ);
    chk("stall_hold_valM", wvalM, 64'h1122334455667788);
    W_stall = 1'b0;
    drive(I_MRMOVQ, 64'd32, 64'd0, RNONE, 4'd3);
    #1;
    chk("stall_no_store", valM, 64'h1122334455667788);
    tick();

    // Address fault boundaries (1016 is the last legal 8-byte address)
    drive(I_RMMOVQ, 64'd1016, 64'h0102030405060708, RNONE, RNONE);
    #1;
    chk("edge_ok_mstat", mstat, S_AOK);
    tick();
    chk("edge_ok_wstat", wstat, S_AOK);
    drive(I_RMMOVQ, 64'd1020, 64'hDEADBEEFDEADBEEF, RNONE, RNONE);
    #1;
    chk("adr_mstat", mstat, S_ADR);
    tick();
    chk("adr_wstat", wstat, S_ADR);
    chk("adr_wicode", wicode, I_RMMOVQ);
    drive(I_RMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEADBEEFDEADBEEF, RNONE, RNONE);
    #1;
    chk("wrap_mstat", mstat, S_ADR);
    tick();
    chk("wrap_wstat", wstat, S_ADR);
    drive(I_MRMOVQ, 64'd1017, 64'd0, RNONE, 4'd3);
    #1;
    chk("adr_ld_valM", valM, 64'd0);
    chk("adr_ld_mstat", mstat, S_ADR);
    tick();
    drive(I_MRMOVQ, 64'd1016, 64'd0, RNONE, 4'd3);
    #1;
    chk("adr_mem_intact", valM, 64'h0102030405060708);
    chk("edge_ld_mstat", mstat, S_AOK);
    tick();
    drive(I_POPQ, 64'd1020, 64'd32, 4'd4, 4'd3);
    #1;
    chk("pop_uses_valA", valM, 64'h1122334455667788);
    chk("pop_mstat", mstat, S_AOK);
    tick();

    // Three wait states
    idle(1);
    sel = 1;
    run_op(I_RMMOVQ, 64'd64, 64'hA5A5000012345678, RNONE, RNONE);
    drive(I_MRMOVQ, 64'd64, 64'd0, RNONE, 4'd5);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w3_busy_%0d", k), busy, 1'b1);
      tick();
      chk($sformatf("w3_nop_%0d", k), wicode, I_NOP);
    end
    chk("w3_busy_done", busy, 1'b0);
    chk("w3_valM", valM, 64'hA5A5000012345678);
    tick();
    chk("w3_wicode", wicode, I_MRMOVQ);
    chk("w3_wvalM", wvalM, 64'hA5A5000012345678);
    chk("w3_wdstM", wdstM, 4'd5);

    // Two wait states, PUSHQ with W stalled for four edges
    idle(1);
    sel = 2;
    run_op(I_RMMOVQ, 64'd128, 64'd0, RNONE, RNONE);
    run_op(I_RMMOVQ, 64'd136, 64'd0, RNONE, RNONE);
    drive(I_PUSHQ, 64'd128, 64'hCAFEF00D8BADBEEF, 4'd4, RNONE);
    W_stall = 1'b1;
    #1;
    chk("w2_busy_0", busy, 1'b1);
    tick();
    chk("w2_busy_1", busy, 1'b1);
    chk("w2_hold_1", wicode, I_RMMOVQ);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk($sformatf("w2_ready_%0d", k), busy, 1'b0);
      chk($sformatf("w2_hold_%0d", k), wicode, I_RMMOVQ);
    end
    W_stall = 1'b0;
    #1;
    tick();
    chk("w2_push_wicode", wicode, I_PUSHQ);
    chk("w2_push_wvalE", wvalE, 64'd128);
    chk("w2_push_wdstE", wdstE, 4'd4);
    run_op(I_MRMOVQ, 64'd128, 64'd0, RNONE, 4'd1);
    chk("w2_rb", wvalM, 64'hCAFEF00D8BADBEEF);
    run_op(I_MRMOVQ, 64'd129, 64'd0, RNONE, 4'd1);
    chk("w2_rb_le", wvalM, 64'h00CAFEF00D8BADBE);
    run_op(I_POPQ, 64'd136, 64'd128, 4'd4, 4'd2);
    chk("w2_pop_valM", wvalM, 64'hCAFEF00D8BADBEEF);
    chk("w2_pop_valE", wvalE, 64'd136);

    // Reset in the middle of a waiting store
    idle(1);
    sel = 1;
    run_op(I_RMMOVQ, 64'd200, 64'h5555555555555555, RNONE, RNONE);
    run_op(I_MRMOVQ, 64'd200, 64'd0, RNONE, 4'd6);
    chk("pre_rst_wdstM", wdstM, 4'd6);
    drive(I_RMMOVQ, 64'd200, 64'h9999999999999999, RNONE, RNONE);
    W_stall = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b1);
    tick();
    chk("mid_hold", wicode, I_MRMOVQ);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wicode", wicode, I_NOP);
    chk("mid_rst_wdstE", wdstE, RNONE);
    chk("mid_rst_wdstM", wdstM, RNONE);
    chk("mid_rst_wvalM", wvalM, 64'd0);
    drive(I_NOP, 64'd0, 64'd0, RNONE, RNONE);
    W_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    tick();
    run_op(I_MRMOVQ, 64'd200, 64'd0, RNONE, 4'd6);
    chk("rst_no_store", wvalM, 64'h5555555555555555);

`ifdef MEM_STATS_EN
    // Access counters at one wait state
    idle(1);
    sel = 3;
    rst_n = 1'b0;
    #1;
    chk("st_rst_loads", o_sl[3], 32'd0);
    chk("st_rst_stores", o_ss[3], 32'd0);
    chk("st_rst_wait", o_sw[3], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(I_RMMOVQ, 64'd300, 64'h0123456789ABCDEF, RNONE, RNONE);
    run_op(I_MRMOVQ, 64'd300, 64'd0, RNONE, 4'd2);
    chk("st_ld_valM", wvalM, 64'h0123456789ABCDEF);
    run_op(I_POPQ, 64'd308, 64'd300, 4'd4, 4'd2);
    idle(1);
    chk("st_loads", o_sl[3], 32'd2);
    chk("st_stores", o_ss[3], 32'd1);
    chk("st_wait", o_sw[3], 32'd3);
`endif

    chk("w0_never_busy", 64'(ever_busy0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_mem_stage_ws.md
Name: y86_mem_stage_ws

Overview:
- Parametrised next-generation Y86-64 memory stage plus M/W pipeline register for the PIPE processor.
- Owns data memory and sits between the execute stage's M register outputs and write-back.
- Adds a configurable access latency (wait states), a busy handshake to the hazard controller, and out-of-range address detection (stat ADR).
- Adds explicit W stall/bubble control and an asynchronous reset.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- MEM_BYTES, 1024, data memory size in bytes; byte-addressed, little-endian.
- WAIT_CYCLES, 0, extra cycles every memory access spends in M; range 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- M_stat  in  2  stat of the instruction in M (0 AOK, 1 HLT, 2 ADR, 3 INS)
- M_icode  in  4  icode in M
- M_cnd  in  1  condition flag in M; passed through, not used
- M_valE  in  DATA_W  ALU result
- M_valA  in  DATA_W  store data, or pop/ret address
- M_dstE  in  4  destination register for valE
- M_dstM  in  4  destination register for valM
- W_stall  in  1  hold the W register
- W_bubble  in  1  load a nop into W
- m_busy  out  1  access still in progress; controller must stall F, D, E and M
- m_valM  out  DATA_W  combinational read data
- m_stat  out  2  combinational stat; becomes ADR on an address fault
- W_stat  out  2  W register stat
- W_icode  out  4  W register icode
- W_valE  out  DATA_W  W register valE
- W_valM  out  DATA_W  W register valM
- W_dstE  out  4  W register dstE
- W_dstM  out  4  W register dstM

Behaviour:
- Reset (async, rst_n=0):
  - W_icode=4'h1 (NOP), W_stat=AOK, W_valE=0, W_valM=0, W_dstE=W_dstM=4'hF.
  - FSM returns to IDLE, wait count=0.
  - Memory contents are not cleared.
  - A reset in the middle of an access abandons it; no write occurs.
- Read ops are MRMOVQ(5), POPQ(B) and RET(9).
  - Address is valE for MRMOVQ, valA for POPQ/RET.
- Write ops are RMMOVQ(4), PUSHQ(A) and CALL(8).
  - Address is valE; data is valA.
- Address fault: addr > MEM_BYTES-DATA_W/8, compared unsigned at full width, so wrap-around is a fault.
  - On a fault: m_stat=ADR, m_valM=0, no write.
  - Otherwise m_stat=M_stat.
- Non-memory icodes, and any instruction with M_stat!=AOK: no memory access, m_busy=0, m_valM=0.
- FSM:
  - IDLE: count=0.
  - WAIT: 0<count<WAIT_CYCLES.
  - READY: count==WAIT_CYCLES, waiting for W_stall to drop.
- m_busy = memory op && M_stat==AOK && count<WAIT_CYCLES.
  - The busy condition covers IDLE, so busy is asserted in the first cycle the op is in M.
- While busy, count increments each clock.
- When busy=0 and W_stall=0, the instruction leaves M and count clears to 0.
- WAIT_CYCLES=0: every access completes in a single cycle; m_busy is never asserted.
- Store commit: on the clock edge with write op && no fault && M_stat==AOK && !m_busy && !W_stall && !W_bubble.
  - Commits exactly once per instruction.
- Reads are combinational from the array.
  - m_valM is valid only when m_busy=0.
- W register update priority: W_stall (hold) > m_busy or W_bubble (load a nop) > load.
  - Nop values: icode 1, stat AOK, dsts F, vals 0.
  - Load takes M_icode, m_stat, M_valE, m_valM, M_dstE, M_dstM.
- W_stall during WAIT: count keeps advancing; the FSM stops in READY until the stall drops.

Optional Feature:
- MEM_STATS_EN defined adds three output ports, each 32 bits and saturating:
  - stat_loads: completed reads.
  - stat_stores: committed writes.
  - stat_wait: cycles with m_busy=1.
- All three counters reset to 0 asynchronously.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package y86_pkg holds:
  - icode localparams (HALT 0, NOP 1, RMMOVQ 4, MRMOVQ 5, CALL 8, RET 9, PUSHQ A, POPQ B).
  - stat encodings (AOK 0, HLT 1, ADR 2, INS 3).
  - RNONE = 4'hF.
- One sub-module: y86_data_mem.
  - Byte array of MEM_BYTES.
  - Combinational DATA_W little-endian read; synchronous write-enable port.

Test Plan:
1. WAIT_CYCLES=0: RMMOVQ valE=32, valA=0x1122334455667788, then MRMOVQ valE=32 -> m_valM=0x1122334455667788, m_busy never high, W_valM updated the next cycle.
2. WAIT_CYCLES=3: MRMOVQ -> m_busy high for exactly 3 cycles with a NOP in W each of those cycles, then W_icode=5 and W_valM correct on the 4th edge.
3. RMMOVQ valE=MEM_BYTES-4 -> m_stat=ADR, W_stat=2, memory unchanged; same for valE=64'hFFFF_FFFF_FFFF_FFFC (wrap-around).
4. WAIT_CYCLES=2 with PUSHQ and W_stall held for 4 cycles -> FSM holds in READY, store commits once, byte read-back at valE matches valA.
5. Assert rst_n=0 while in WAIT during an RMMOVQ -> W_icode=1, W_dstE=F immediately, m_busy=0 after reset release, target bytes unchanged.
6. With MEM_STATS_EN: 2 loads + 1 store at WAIT_CYCLES=1 -> stat_loads=2, stat_stores=1, stat_wait=3.
